rca_pipe: RTL

Parametrised, pipelined ripple-carry add/subtract unit and the next generation of the team's 64-bit ripple-carry adder. The operand is split into STAGES equal chunks, one chunk is added per pipeline stage, and the carry is registered between stages. Adds a subtract mode, a signed-overflow flag and a valid/ready handshake on both sides, so the block can sit directly in a streaming datapath at full clock rate.

---
 rtl/rca_pkg.sv | 16 +
 rtl/rca_chunk.sv | 34 +++
 rtl/rca_pipe.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared helpers for the pipelined ripple-carry add/subtract unit.
// Latency: n/a (elaboration-time constants and checks only).
// Backpressure: n/a.
package rca_pkg;

  // Bits added by each pipeline stage.
  function automatic int chunk_bits(input int width, input int stages);
    return width / stages;
  endfunction

  // Legal geometry: 1..width stages, and the width splits evenly across them.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder slice, one per pipeline stage.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; holds no state.
module rca_chunk
  import rca_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] c;

  // Bit-serial ripple: c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[W];
  // Carry into the MSB; only the top slice's value matters (signed overflow).
  assign cmsb = c[W-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry add/subtract, one CHUNK-bit slice per stage, carry registered between stages.
// Latency: STAGES cycles (accepted at edge N, out_valid after edge N+STAGES-1); 1 beat/cycle.
// Backpressure: ready_k = !valid_k || ready_{k+1}; bubbles collapse; in_ready is combinational from out_ready.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CHUNK = chunk_bits(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("rca_pipe: STAGES must be in 1..WIDTH and divide WIDTH evenly");
  end

  // Per-stage state. word_q packs {completed sum bits (top), pending A bits (bottom)}:
  // each stage shifts right by CHUNK and drops its slice result in at the top, so the
  // completed field grows and the pending field shrinks by CHUNK per stage.
  // pb_q carries the pending (already conditionally inverted) B bits, right-justified.
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] vin;
  logic [STAGES-1:0] rdy;
  logic [WIDTH-1:0]  word_q [STAGES];
  logic [WIDTH-1:0]  pb_q   [STAGES];
  logic              c_q    [STAGES];
  logic              ovf_q;

  // Stage inputs and slice results.
  logic [WIDTH-1:0]  in_w   [STAGES];
  logic [WIDTH-1:0]  in_b   [STAGES];
  logic              in_c   [STAGES];
  logic [WIDTH-1:0]  nxt_w  [STAGES];
  logic [CHUNK-1:0]  ch_sum [STAGES];
  logic              ch_cout[STAGES];
  logic              ch_cmsb[STAGES];

  // Stage inputs: stage 0 takes the ports (B inverted and carry forced for subtract),
  // later stages take the previous stage's registers.
  always_comb begin
    vin = '0;
    for (int k = 0; k < STAGES; k++) begin
      in_w[k] = '0;
      in_b[k] = '0;
      in_c[k] = 1'b0;
    end
    in_w[0] = a;
    in_b[0] = sub ? ~b : b;
    in_c[0] = sub | cin;
    vin[0]  = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      in_w[k] = word_q[k-1];
      in_b[k] = pb_q[k-1];
      in_c[k] = c_q[k-1];
      vin[k]  = vld[k-1];
    end
  end

  // Ready chain from the output back to the input; an empty stage always accepts.
  always_comb begin
    logic r;
    r   = out_ready;
    rdy = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      r      = !vld[k] || r;
      rdy[k] = r;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_chunk #(.W(CHUNK)) u_chunk (
      .a    (in_w[k][CHUNK-1:0]),
      .b    (in_b[k][CHUNK-1:0]),
      .cin  (in_c[k]),
      .sum  (ch_sum[k]),
      .cout (ch_cout[k]),
      .cmsb (ch_cmsb[k])
    );
    assign nxt_w[k] = (WIDTH'(ch_sum[k]) << (WIDTH - CHUNK)) | (in_w[k] >> CHUNK);
  end

  // Stage registers: advance where the stage is ready; hold (stable outputs) otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        word_q[k] <= '0;
        pb_q[k]   <= '0;
        c_q[k]    <= 1'b0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          vld[k] <= vin[k];
          if (vin[k]) begin
            word_q[k] <= nxt_w[k];
            pb_q[k]   <= in_b[k] >> CHUNK;
            c_q[k]    <= ch_cout[k];
          end
        end
      end
      if (rdy[STAGES-1] && vin[STAGES-1]) begin
        ovf_q <= ch_cmsb[STAGES-1] ^ ch_cout[STAGES-1];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[STAGES-1];
  assign sum       = word_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
